// File: rtl/axi4_lite_arbiter_pkg.sv
// Shared AXI4-Lite arbiter types: FSM states, response codes, master ids, latched transaction.
package axi4_lite_arbiter_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned RESP_W = 2;
    localparam int unsigned CNT_W  = 8;

    localparam logic [RESP_W-1:0] RESP_OKAY   = 2'b00;
    localparam logic [RESP_W-1:0] RESP_SLVERR = 2'b10;
    localparam logic [RESP_W-1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_WAIT = 2'd2,
        ST_RESP = 2'd3
    } state_t;

    // Master id: m0 is the IFU (read-only), m1 is the LSU.
    typedef enum logic {
        MID_M0 = 1'b0,
        MID_M1 = 1'b1
    } mid_t;

    typedef struct packed {
        mid_t              id;
        logic              is_write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } txn_t;

endpackage

// File: rtl/axi4_lite_arbiter_rr.sv
// Two-way round-robin grant: on a tie, grant the requester that was not granted last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] grant
);

    // One-hot grant; last=1 means m1 was granted most recently.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = last ? 2'b01 : 2'b10;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/axi4_lite_arbiter.sv
// Two-master, one-slave AXI4-Lite arbiter with a single outstanding transaction and response timeout.
module axi4_lite_arbiter
    import axi4_lite_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              resetn,
    // master 0 (IFU) read
    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [RESP_W-1:0] m0_rresp,
    // master 1 (LSU) read/write
    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    input  logic              m1_awvalid,
    input  logic [ADDR_W-1:0] m1_awaddr,
    input  logic              m1_wvalid,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_arready,
    output logic              m1_awready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [RESP_W-1:0] m1_rresp,
    output logic              m1_bvalid,
    output logic [RESP_W-1:0] m1_bresp,
    // shared slave
    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    output logic              s_awvalid,
    output logic [ADDR_W-1:0] s_awaddr,
    output logic              s_wvalid,
    output logic [DATA_W-1:0] s_wdata,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [RESP_W-1:0] s_rresp,
    input  logic              s_bvalid,
    input  logic [RESP_W-1:0] s_bresp
);

    state_t            state_q, state_d;
    txn_t              txn_q, txn_d;
    mid_t              last_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        req, grant;
    logic              m1_wr_cand;
    logic              take;
    logic              rsp_hit;
    logic              timeout_hit;
    logic              rsp_load;
    logic [DATA_W-1:0] rsp_data;
    logic [RESP_W-1:0] rsp_code;

    // m1 candidate: a complete write beats a read.
    assign m1_wr_cand = m1_awvalid & m1_wvalid;
    assign req        = {m1_wr_cand | m1_arvalid, m0_arvalid};

    rr_arb2 u_rr_arb2 (
        .req   (req),
        .last  (last_q == MID_M1),
        .grant (grant)
    );

    // Only the response channel matching the outstanding kind counts.
    assign rsp_hit  = txn_q.is_write ? s_bvalid : s_rvalid;
    assign rsp_load = (state_d == ST_RESP) && (state_q != ST_RESP);
    assign rsp_data = timeout_hit ? '0 : s_rdata;
    assign rsp_code = timeout_hit ? RESP_DECERR : (txn_q.is_write ? s_bresp : s_rresp);

    // State register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, grant capture and same-cycle acceptance pulses (ready gated off while in reset).
    always_comb begin
        state_d     = state_q;
        txn_d       = txn_q;
        take        = 1'b0;
        timeout_hit = 1'b0;
        m0_arready  = 1'b0;
        m1_arready  = 1'b0;
        m1_awready  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (resetn && (grant != 2'b00)) begin
                    take    = 1'b1;
                    state_d = ST_REQ;
                    if (grant[0]) begin
                        m0_arready     = 1'b1;
                        txn_d.id       = MID_M0;
                        txn_d.is_write = 1'b0;
                        txn_d.addr     = m0_araddr;
                        txn_d.data     = '0;
                    end else if (m1_wr_cand) begin
                        m1_awready     = 1'b1;
                        txn_d.id       = MID_M1;
                        txn_d.is_write = 1'b1;
                        txn_d.addr     = m1_awaddr;
                        txn_d.data     = m1_wdata;
                    end else begin
                        m1_arready     = 1'b1;
                        txn_d.id       = MID_M1;
                        txn_d.is_write = 1'b0;
                        txn_d.addr     = m1_araddr;
                        txn_d.data     = '0;
                    end
                end
            end
            ST_REQ: begin
                state_d = rsp_hit ? ST_RESP : ST_WAIT;
            end
            ST_WAIT: begin
                if (rsp_hit) begin
                    state_d = ST_RESP;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d     = ST_RESP;
                    timeout_hit = 1'b1;
                end
            end
            ST_RESP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Transaction latch, round-robin history, wait counter and slave request outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            txn_q     <= '0;
            last_q    <= MID_M1;
            cnt_q     <= '0;
            s_arvalid <= 1'b0;
            s_awvalid <= 1'b0;
            s_wvalid  <= 1'b0;
            s_araddr  <= '0;
            s_awaddr  <= '0;
            s_wdata   <= '0;
        end else begin
            txn_q     <= txn_d;
            s_arvalid <= take & ~txn_d.is_write;
            s_awvalid <= take & txn_d.is_write;
            s_wvalid  <= take & txn_d.is_write;
            if (take) begin
                last_q   <= txn_d.id;
                cnt_q    <= '0;
                s_araddr <= txn_d.addr;
                s_awaddr <= txn_d.addr;
                s_wdata  <= txn_d.data;
            end else if (state_q == ST_WAIT) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    // Master responses: one-cycle valid to the owner; data/resp hold between responses.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            m0_rvalid <= 1'b0;
            m0_rdata  <= '0;
            m0_rresp  <= '0;
            m1_rvalid <= 1'b0;
            m1_rdata  <= '0;
            m1_rresp  <= '0;
            m1_bvalid <= 1'b0;
            m1_bresp  <= '0;
        end else begin
            m0_rvalid <= 1'b0;
            m1_rvalid <= 1'b0;
            m1_bvalid <= 1'b0;
            if (rsp_load) begin
                if (txn_q.is_write) begin
                    m1_bvalid <= 1'b1;
                    m1_bresp  <= rsp_code;
                end else if (txn_q.id == MID_M0) begin
                    m0_rvalid <= 1'b1;
                    m0_rdata  <= rsp_data;
                    m0_rresp  <= rsp_code;
                end else begin
                    m1_rvalid <= 1'b1;
                    m1_rdata  <= rsp_data;
                    m1_rresp  <= rsp_code;
                end
            end
        end
    end

endmodule

// File: tb/tb_axi4_lite_arbiter.sv
// Directed bench for axi4_lite_arbiter: vector table of single transactions plus multi-cycle corner sequences.
module tb_axi4_lite_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        m0_arvalid;
    logic [31:0] m0_araddr;
    logic        m0_arready;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m1_arvalid;
    logic [31:0] m1_araddr;
    logic        m1_awvalid;
    logic [31:0] m1_awaddr;
    logic        m1_wvalid;
    logic [31:0] m1_wdata;
    logic        m1_arready;
    logic        m1_awready;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_bvalid;
    logic [1:0]  m1_bresp;
    logic        s_arvalid;
    logic [31:0] s_araddr;
    logic        s_awvalid;
    logic [31:0] s_awaddr;
    logic        s_wvalid;
    logic [31:0] s_wdata;
    logic        s_rvalid;
    logic [31:0] s_rdata;
    logic [1:0]  s_rresp;
    logic        s_bvalid;
    logic [1:0]  s_bresp;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi4_lite_arbiter #(.TIMEOUT(16)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .m0_arvalid (m0_arvalid),
        .m0_araddr  (m0_araddr),
        .m0_arready (m0_arready),
        .m0_rvalid  (m0_rvalid),
        .m0_rdata   (m0_rdata),
        .m0_rresp   (m0_rresp),
        .m1_arvalid (m1_arvalid),
        .m1_araddr  (m1_araddr),
        .m1_awvalid (m1_awvalid),
        .m1_awaddr  (m1_awaddr),
        .m1_wvalid  (m1_wvalid),
        .m1_wdata   (m1_wdata),
        .m1_arready (m1_arready),
        .m1_awready (m1_awready),
        .m1_rvalid  (m1_rvalid),
        .m1_rdata   (m1_rdata),
        .m1_rresp   (m1_rresp),
        .m1_bvalid  (m1_bvalid),
        .m1_bresp   (m1_bresp),
        .s_arvalid  (s_arvalid),
        .s_araddr   (s_araddr),
        .s_awvalid  (s_awvalid),
        .s_awaddr   (s_awaddr),
        .s_wvalid   (s_wvalid),
        .s_wdata    (s_wdata),
        .s_rvalid   (s_rvalid),
        .s_rdata    (s_rdata),
        .s_rresp    (s_rresp),
        .s_bvalid   (s_bvalid),
        .s_bresp    (s_bresp)
    );

    // One transaction: requests presented, slave reply (data/resp), expected ready one-hot and response.
    typedef struct {
        logic        m0_ar;
        logic        m1_ar;
        logic        m1_wr;
        logic [31:0] rdata;
        logic [1:0]  resp;
        logic [2:0]  exp_ready;   // {m0_arready, m1_arready, m1_awready}
        logic [31:0] exp_data;
        logic [1:0]  exp_resp;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic clear_masters();
        m0_arvalid = 1'b0;
        m1_arvalid = 1'b0;
        m1_awvalid = 1'b0;
        m1_wvalid  = 1'b0;
    endtask

    // Drive one vector at cycle T and check T (ready), T+1 (slave request), T+3 (response), T+4 (idle).
    task automatic run_vec(input vec_t v, input string tag);
        logic        is_wr;
        logic [2:0]  exp_v;
        logic [31:0] exp_addr;
        @(negedge clk);
        m0_arvalid = v.m0_ar;
        m0_araddr  = 32'h2000_0000;
        m1_arvalid = v.m1_ar;
        m1_araddr  = 32'h2000_0008;
        m1_awvalid = v.m1_wr;
        m1_wvalid  = v.m1_wr;
        m1_awaddr  = 32'h2000_0000;
        m1_wdata   = 32'h0000_DEAD;
        #1;
        check({tag, "/ready"}, 32'({m0_arready, m1_arready, m1_awready}), 32'(v.exp_ready));
        is_wr    = v.exp_ready[0];
        exp_v    = v.exp_ready[2] ? 3'b100 : (v.exp_ready[1] ? 3'b010 : 3'b001);
        exp_addr = v.exp_ready[2] ? 32'h2000_0000 : 32'h2000_0008;
        @(negedge clk);
        clear_masters();
        check({tag, "/s_valid_req"}, 32'({s_arvalid, s_awvalid, s_wvalid}),
              is_wr ? 32'h3 : 32'h4);
        if (is_wr) begin
            check({tag, "/s_awaddr"}, s_awaddr, 32'h2000_0000);
            check({tag, "/s_wdata"}, s_wdata, 32'h0000_DEAD);
        end else begin
            check({tag, "/s_araddr"}, s_araddr, exp_addr);
        end
        @(negedge clk);
        check({tag, "/s_valid_wait"}, 32'({s_arvalid, s_awvalid, s_wvalid}), 32'h0);
        if (is_wr) begin
            s_bvalid = 1'b1;
            s_bresp  = v.resp;
        end else begin
            s_rvalid = 1'b1;
            s_rdata  = v.rdata;
            s_rresp  = v.resp;
        end
        @(negedge clk);
        s_rvalid = 1'b0;
        s_bvalid = 1'b0;
        check({tag, "/rsp_valid"}, 32'({m0_rvalid, m1_rvalid, m1_bvalid}), 32'(exp_v));
        if (exp_v == 3'b100) begin
            check({tag, "/m0_rdata"}, m0_rdata, v.exp_data);
            check({tag, "/m0_rresp"}, 32'(m0_rresp), 32'(v.exp_resp));
        end else if (exp_v == 3'b010) begin
            check({tag, "/m1_rdata"}, m1_rdata, v.exp_data);
            check({tag, "/m1_rresp"}, 32'(m1_rresp), 32'(v.exp_resp));
        end else begin
            check({tag, "/m1_bresp"}, 32'(m1_bresp), 32'(v.exp_resp));
        end
        @(negedge clk);
        check({tag, "/rsp_done"}, 32'({m0_rvalid, m1_rvalid, m1_bvalid}), 32'h0);
    endtask

    initial begin
        // m0_ar m1_ar m1_wr rdata          resp   ready   exp_data       exp_resp
        vecs[0] = '{1'b1, 1'b1, 1'b0, 32'h0000_0011, 2'b00, 3'b100, 32'h0000_0011, 2'b00};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 32'h0000_0022, 2'b00, 3'b010, 32'h0000_0022, 2'b00};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_0033, 2'b00, 3'b100, 32'h0000_0033, 2'b00};
        vecs[3] = '{1'b1, 1'b0, 1'b0, 32'h0000_0005, 2'b00, 3'b100, 32'h0000_0005, 2'b00};
        vecs[4] = '{1'b0, 1'b1, 1'b1, 32'h0000_0000, 2'b00, 3'b001, 32'h0000_0000, 2'b00};
        vecs[5] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, 2'b10, 3'b010, 32'h0000_1234, 2'b10};
        vecs[6] = '{1'b1, 1'b0, 1'b1, 32'h0000_0044, 2'b00, 3'b100, 32'h0000_0044, 2'b00};
        vecs[7] = '{1'b1, 1'b0, 1'b1, 32'h0000_0000, 2'b10, 3'b001, 32'h0000_0000, 2'b10};

        resetn    = 1'b0;
        clear_masters();
        m0_araddr = '0;
        m1_araddr = '0;
        m1_awaddr = '0;
        m1_wdata  = '0;
        s_rvalid  = 1'b0;
        s_rdata   = '0;
        s_rresp   = '0;
        s_bvalid  = 1'b0;
        s_bresp   = '0;

        // Reset state.
        repeat (2) @(negedge clk);
        check("rst/s_valids", 32'({s_arvalid, s_awvalid, s_wvalid}), 32'h0);
        check("rst/m_valids", 32'({m0_rvalid, m1_rvalid, m1_bvalid}), 32'h0);
        check("rst/readys", 32'({m0_arready, m1_arready, m1_awready}), 32'h0);
        check("rst/rdata", m0_rdata | m1_rdata, 32'h0);
        resetn = 1'b1;
        @(negedge clk);

        // Table: round-robin ties, lone reads, write-over-read, SLVERR forwarding.
        for (int i = 0; i < 8; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Timeout: m1 read never answered, DECERR after 16 WAIT cycles.
        @(negedge clk);
        m1_arvalid = 1'b1;
        m1_araddr  = 32'h3000_0000;
        #1;
        check("to/ready", 32'(m1_arready), 32'h1);
        @(negedge clk);
        clear_masters();
        check("to/s_araddr", s_araddr, 32'h3000_0000);
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            check($sformatf("to/quiet%0d", k), 32'({m0_rvalid, m1_rvalid, m1_bvalid}), 32'h0);
        end
        @(negedge clk);
        check("to/m1_rvalid", 32'(m1_rvalid), 32'h1);
        check("to/m1_rresp", 32'(m1_rresp), 32'h3);
        check("to/m1_rdata", m1_rdata, 32'h0);
        @(negedge clk);
        check("to/done", 32'(m1_rvalid), 32'h0);

        // Response on the timeout cycle is forwarded, not DECERR.
        @(negedge clk);
        m0_arvalid = 1'b1;
        m0_araddr  = 32'h2000_0004;
        #1;
        check("tc/ready", 32'(m0_arready), 32'h1);
        @(negedge clk);
        clear_masters();
        for (int k = 2; k <= 17; k++) begin
            @(negedge clk);
            if (k == 17) begin
                s_rvalid = 1'b1;
                s_rdata  = 32'h0000_CAFE;
                s_rresp  = 2'b00;
            end
        end
        @(negedge clk);
        s_rvalid = 1'b0;
        check("tc/valids", 32'({m0_rvalid, m1_rvalid, m1_bvalid}), 32'h4);
        check("tc/m0_rdata", m0_rdata, 32'h0000_CAFE);
        check("tc/m0_rresp", 32'(m0_rresp), 32'h0);

        // Stray s_rvalid in IDLE, then s_bvalid during a read: both ignored.
        @(negedge clk);
        s_rvalid = 1'b1;
        s_rdata  = 32'h0000_0BAD;
        @(negedge clk);
        s_rvalid = 1'b0;
        check("stray/idle_valids", 32'({m0_rvalid, m1_rvalid, m1_bvalid}), 32'h0);
        m0_arvalid = 1'b1;
        m0_araddr  = 32'h2000_0000;
        #1;
        check("stray/ready", 32'(m0_arready), 32'h1);
        @(negedge clk);
        clear_masters();
        check("stray/s_arvalid", 32'(s_arvalid), 32'h1);
        @(negedge clk);
        s_bvalid = 1'b1;
        s_bresp  = 2'b10;
        @(negedge clk);
        s_bvalid = 1'b0;
        check("stray/b_ignored", 32'({m0_rvalid, m1_rvalid, m1_bvalid}), 32'h0);
        s_rvalid = 1'b1;
        s_rdata  = 32'h0000_0077;
        s_rresp  = 2'b00;
        @(negedge clk);
        s_rvalid = 1'b0;
        check("stray/valids", 32'({m0_rvalid, m1_rvalid, m1_bvalid}), 32'h4);
        check("stray/m0_rdata", m0_rdata, 32'h0000_0077);
        @(negedge clk);

        // Reset during WAIT: outputs clear at once, no response, then normal operation.
        @(negedge clk);
        m1_arvalid = 1'b1;
        m1_araddr  = 32'h3000_0000;
        #1;
        check("rw/ready", 32'(m1_arready), 32'h1);
        @(negedge clk);
        clear_masters();
        repeat (2) @(negedge clk);
        m0_arvalid = 1'b1;
        resetn     = 1'b0;
        #1;
        check("rw/readys", 32'({m0_arready, m1_arready, m1_awready}), 32'h0);
        check("rw/s_valids", 32'({s_arvalid, s_awvalid, s_wvalid}), 32'h0);
        check("rw/m_valids", 32'({m0_rvalid, m1_rvalid, m1_bvalid}), 32'h0);
        check("rw/m0_rdata", m0_rdata, 32'h0);
        check("rw/m1_rresp", 32'(m1_rresp), 32'h0);
        repeat (2) @(negedge clk);
        m0_arvalid = 1'b0;
        resetn     = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            check($sformatf("rw/dropped%0d", k),
                  32'({m0_rvalid, m1_rvalid, m1_bvalid, s_arvalid}), 32'h0);
        end
        run_vec('{1'b0, 1'b1, 1'b0, 32'h0000_0055, 2'b00, 3'b010, 32'h0000_0055, 2'b00}, "rw/after");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/axi4_lite_arbiter.md
AXI4_LITE_ARBITER -- requirements
Module: axi4_lite_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum WAIT cycles before a synthesized error response; legal range 2..255.
REQ-002 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-003 SHALL have port resetn, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have m0_arvalid / m0_araddr, input, 1/32: read request from master 0 (IFU), held until accepted.
REQ-005 SHALL have m0_arready, output, 1: one-cycle acceptance pulse for the m0 read.
REQ-006 SHALL have m0_rvalid / m0_rdata / m0_rresp, output, 1/32/2: read response to m0, valid one cycle.
REQ-007 SHALL have m1_arvalid / m1_araddr, input, 1/32: read request from master 1 (LSU), held until accepted.
REQ-008 SHALL have m1_awvalid / m1_awaddr / m1_wvalid / m1_wdata, input, 1/32/1/32: write request from m1, held until accepted.
REQ-009 SHALL have m1_arready / m1_awready, output, 1/1: one-cycle acceptance pulses for the m1 read and write.
REQ-010 SHALL have m1_rvalid / m1_rdata / m1_rresp, output, 1/32/2: read response to m1, valid one cycle.
REQ-011 SHALL have m1_bvalid / m1_bresp, output, 1/2: write response to m1, valid one cycle.
REQ-012 SHALL have s_arvalid / s_araddr, output, 1/32: read request to the shared slave (CLINT/device bus).
REQ-013 SHALL have s_awvalid / s_awaddr / s_wvalid / s_wdata, output, 1/32/1/32: write request to the shared slave.
REQ-014 SHALL have s_rvalid / s_rdata / s_rresp and s_bvalid / s_bresp, input, 1/32/2 and 1/2: slave responses.

Function
REQ-015 SHALL implement FSM IDLE -> REQ -> WAIT -> RESP -> IDLE, with exactly one transaction outstanding.
REQ-016 In IDLE, if there is no candidate, SHALL stay in IDLE. The m1 candidate is a write if awvalid && wvalid, otherwise a read if arvalid; a write wins over a read within m1.
REQ-017 If m0 and m1 both have candidates, SHALL grant the master not granted last (round-robin); last_grant resets to m1, so m0 wins the first tie.
REQ-018 On grant in IDLE, SHALL pulse the matching ready (m0_arready, m1_arready or m1_awready) for that cycle, latch master id, kind, address and data, update last_grant, and enter REQ.
REQ-019 In REQ (exactly one cycle), SHALL drive s_arvalid, or s_awvalid and s_wvalid together, with the latched address/data; all s_*valid SHALL be 0 in every other state.
REQ-020 SHALL accept the slave response (s_rvalid for reads, s_bvalid for writes) in REQ or WAIT, latch data/resp, and enter RESP.
REQ-021 In WAIT, SHALL increment an 8-bit counter cleared on REQ entry; if no response by count TIMEOUT-1, SHALL enter RESP with resp 2'b11 (DECERR) and rdata 0.
REQ-022 If a response arrives on the same cycle as the timeout, SHALL forward the response, not DECERR.
REQ-023 In RESP, SHALL assert exactly one of m0_rvalid, m1_rvalid or m1_bvalid for one cycle, per latched id and kind, then return to IDLE.
REQ-024 Latency: acceptance at cycle T, REQ at T+1, CLINT response at T+2, master response at T+3, next acceptance no earlier than T+4.
REQ-025 SHALL ignore slave responses arriving in IDLE or RESP, and mismatched kinds (e.g. s_bvalid during a read).
REQ-026 Master response data/resp outputs SHALL hold their last value when their valid is low; ready outputs are 0 outside IDLE.

Reset
REQ-027 On resetn low, SHALL immediately, even mid-transaction, go to IDLE. All valid and ready outputs go to 0, rdata/resp registers to 0, the counter to 0, and last_grant to m1; an in-flight transaction is dropped without a response.

Structure
REQ-028 SHALL place the FSM state enum, the RESP_OKAY=2'b00, RESP_SLVERR=2'b10 and RESP_DECERR=2'b11 constants, and the master-id encoding in the shared AXI4-Lite package.
REQ-029 SHALL factor the two-way round-robin grant into one sub-module, rr_arb2 (req[1:0], last, grant[1:0]); all else stays flat.

Verification
REQ-030 m0 read 0x20000000 alone with CLINT mtime=5 at sample -> m0_arready at T, s_arvalid at T+1 only, m0_rvalid at T+3 with rdata 5, rresp 00.
REQ-031 m0 read and m1 read both asserted three times back-to-back -> grant order m0, m1, m0; each response goes only to its requester.
REQ-032 m1 write 0x20000000 with wdata 0xDEAD -> m1_awready pulse, s_awvalid=s_wvalid=1 for one cycle, m1_bvalid with bresp 00; m1 simultaneous arvalid is deferred.
REQ-033 m1 read 0x30000000 (CLINT never responds), TIMEOUT=16 -> m1_rvalid exactly 16 WAIT cycles after REQ, rresp 11, rdata 0.
REQ-034 Reset asserted during WAIT -> all outputs 0 asynchronously, no response delivered; after release, a new m1 read completes with normal latency.
REQ-035 Inject a stray s_rvalid in IDLE and s_bvalid during a read -> no master valid is asserted and the FSM is unaffected.
